// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns single-word write/read commands into AXI4-Lite channel transactions.
// Build option AXI_LITE_MASTER_WSTRB_EN adds a wstrb_in port for per-write byte strobes.
//
// state        | meaning
// W_IDLE       | write path free, waiting for start_write
// W_ADDR_DATA  | AW and/or W beat still outstanding
// W_RESP       | both beats accepted, waiting for B
// R_IDLE       | read path free, waiting for start_read
// R_ADDR       | AR beat outstanding
// R_DATA       | waiting for R
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start_write,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
`ifdef AXI_LITE_MASTER_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]   wstrb_in,
`endif
    output logic                      w_busy,
    output logic                      w_done,
    output logic                      w_error,
    input  logic                      start_read,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic                      r_busy,
    output logic                      r_done,
    output logic                      r_error,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [2:0]                axi_awprot,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [2:0]                axi_arprot,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    output logic                      axi_rready
);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_ADDR_DATA = 2'd1;
    localparam logic [1:0] W_RESP      = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0] w_state;
    logic [1:0] r_state;
    logic       unused_resp;

    // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp = axi_bresp[0] ^ axi_rresp[0];
    assign axi_awprot  = 3'b000;
    assign axi_arprot  = 3'b000;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            axi_awaddr  <= '0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            w_busy      <= 1'b0;
            w_done      <= 1'b0;
            w_error     <= 1'b0;
        end else begin
            w_done <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (start_write) begin
                        axi_awaddr  <= waddr;
                        axi_wdata   <= wdata;
`ifdef AXI_LITE_MASTER_WSTRB_EN
                        axi_wstrb   <= wstrb_in;
`else
                        axi_wstrb   <= '1;
`endif
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        w_busy      <= 1'b1;
                        w_error     <= 1'b0;
                        w_state     <= W_ADDR_DATA;
                    end
                end
                W_ADDR_DATA: begin
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    // AW and W may complete in either order or together.
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        w_error    <= axi_bresp[1];
                        w_done     <= 1'b1;
                        w_busy     <= 1'b0;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            rdata       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (start_read) begin
                        axi_araddr  <= raddr;
                        axi_arvalid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_error     <= 1'b0;
                        r_state     <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        rdata      <= axi_rdata;
                        r_error    <= axi_rresp[1];
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table vectors, hand-written corner sequences and
// randomized transactions against a latency/response model, with a reactive slave.
module tb_axi_lite_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          aclk        = 1'b0;
    logic          aresetn     = 1'b1;
    logic          start_write = 1'b0;
    logic [AW-1:0] waddr       = '0;
    logic [DW-1:0] wdata       = '0;
`ifdef AXI_LITE_MASTER_WSTRB_EN
    logic [SW-1:0] wstrb_in    = '0;
`endif
    logic          start_read  = 1'b0;
    logic [AW-1:0] raddr       = '0;
    logic          w_busy, w_done, w_error, r_busy, r_done, r_error;
    logic [DW-1:0] rdata;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic [2:0]    axi_awprot, axi_arprot;
    logic          axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_awready = 1'b0;
    logic          axi_wready  = 1'b0;
    logic [1:0]    axi_bresp   = 2'b00;
    logic          axi_bvalid  = 1'b0;
    logic          axi_arready = 1'b0;
    logic [DW-1:0] axi_rdata   = '0;
    logic [1:0]    axi_rresp   = 2'b00;
    logic          axi_rvalid  = 1'b0;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .start_write(start_write), .waddr(waddr), .wdata(wdata),
`ifdef AXI_LITE_MASTER_WSTRB_EN
        .wstrb_in(wstrb_in),
`endif
        .w_busy(w_busy), .w_done(w_done), .w_error(w_error),
        .start_read(start_read), .raddr(raddr),
        .r_busy(r_busy), .r_done(r_done), .r_error(r_error), .rdata(rdata),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          dw;
        bit          dr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          awd;
        int          wdd;
        int          bd;
        logic [1:0]  bresp;
        logic [31:0] ra;
        int          ard;
        int          rd;
        logic [1:0]  rresp;
        logic [31:0] rdat;
        int          exp_wcyc;
        bit          exp_werr;
        int          exp_awc;
        int          exp_wc;
        int          exp_rcyc;
        bit          exp_rerr;
    } vec_t;

    // Slave behaviour knobs, read by the reactive slave on the falling edge.
    int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]    s_bresp  = 2'b00, s_rresp = 2'b00;
    logic [DW-1:0] s_rdata  = '0;

    int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int            aw_total = 0, ar_total = 0;
    logic [AW-1:0] mon_awaddr = '0, mon_araddr = '0;
    logic [DW-1:0] mon_wdata = '0;
    logic [SW-1:0] mon_wstrb = '0;
    bit            hold_aw = 1'b0, hold_w = 1'b0, hold_ar = 1'b0;
    logic [AW-1:0] held_awaddr = '0, held_araddr = '0;
    logic [DW-1:0] held_wdata = '0;

    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
            axi_arready = 1'b0; axi_rvalid = 1'b0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (axi_awvalid) begin axi_awready = (aw_wait >= aw_delay); aw_wait++; end
            else begin axi_awready = 1'b0; aw_wait = 0; end
            if (axi_wvalid) begin axi_wready = (w_wait >= w_delay); w_wait++; end
            else begin axi_wready = 1'b0; w_wait = 0; end
            if (axi_arvalid) begin axi_arready = (ar_wait >= ar_delay); ar_wait++; end
            else begin axi_arready = 1'b0; ar_wait = 0; end
            if (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs) begin
                axi_bvalid = (b_wait >= b_delay); axi_bresp = s_bresp; b_wait++;
            end else begin axi_bvalid = 1'b0; b_wait = 0; end
            if (ar_hs > r_hs) begin
                axi_rvalid = (r_wait >= r_delay); axi_rresp = s_rresp; axi_rdata = s_rdata; r_wait++;
            end else begin axi_rvalid = 1'b0; r_wait = 0; end
        end
    end

    // Handshake monitor plus VALID/payload stability while waiting for READY.
    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            hold_aw = 1'b0; hold_w = 1'b0; hold_ar = 1'b0;
        end else begin
            if (hold_aw) check("aw_stable", {axi_awvalid, axi_awaddr}, {1'b1, held_awaddr});
            if (hold_w)  check("w_stable", {axi_wvalid, axi_wdata}, {1'b1, held_wdata});
            if (hold_ar) check("ar_stable", {axi_arvalid, axi_araddr}, {1'b1, held_araddr});
            hold_aw = axi_awvalid && !axi_awready; held_awaddr = axi_awaddr;
            hold_w  = axi_wvalid && !axi_wready;   held_wdata  = axi_wdata;
            hold_ar = axi_arvalid && !axi_arready; held_araddr = axi_araddr;
            if (axi_awvalid && axi_awready) begin aw_hs++; aw_total++; mon_awaddr = axi_awaddr; end
            if (axi_wvalid && axi_wready) begin w_hs++; mon_wdata = axi_wdata; mon_wstrb = axi_wstrb; end
            if (axi_bvalid && axi_bready) b_hs++;
            if (axi_arvalid && axi_arready) begin ar_hs++; ar_total++; mon_araddr = axi_araddr; end
            if (axi_rvalid && axi_rready) r_hs++;
        end
    end

    function automatic logic [SW-1:0] exp_strb(input logic [SW-1:0] ws);
`ifdef AXI_LITE_MASTER_WSTRB_EN
        return ws;
`else
        return ws | {SW{1'b1}};
`endif
    endfunction

    // Reference: done arrives 3 cycles after acceptance plus slave stalls;
    // the slower of AW/W gates the response phase.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.exp_wcyc = 3 + ((v.awd > v.wdd) ? v.awd : v.wdd) + v.bd;
        m.exp_werr = v.bresp[1];
        m.exp_awc  = v.awd + 1;
        m.exp_wc   = v.wdd + 1;
        m.exp_rcyc = 3 + v.ard + v.rd;
        m.exp_rerr = v.rresp[1];
        return m;
    endfunction

    task automatic issue(input bit dw, input bit dr, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        @(negedge aclk);
        start_write = dw; waddr = wa; wdata = wd;
        start_read  = dr; raddr = ra;
        @(posedge aclk); #1;
        start_write = 1'b0; start_read = 1'b0;
    endtask

    task automatic wait_w(output int cyc, output int awc, output int wvc);
        bit got = 1'b0;
        cyc = -1;
        awc = int'(axi_awvalid);
        wvc = int'(axi_wvalid);
        for (int k = 1; k <= 100 && !got; k++) begin
            @(posedge aclk); #1;
            if (w_done) begin got = 1'b1; cyc = k + 1; end
            else begin awc += int'(axi_awvalid); wvc += int'(axi_wvalid); end
        end
        check("w_done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            @(posedge aclk); #1;
            check("w_done_pulse", {63'd0, w_done}, 64'd0);
        end
    endtask

    task automatic wait_r(output int cyc);
        bit got = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(posedge aclk); #1;
            if (r_done) begin got = 1'b1; cyc = k + 1; end
        end
        check("r_done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            @(posedge aclk); #1;
            check("r_done_pulse", {63'd0, r_done}, 64'd0);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int wc = 0, awc = 0, wvc = 0, rc = 0, aw0, ar0;
        aw_delay = v.awd; w_delay = v.wdd; b_delay = v.bd; s_bresp = v.bresp;
        ar_delay = v.ard; r_delay = v.rd; s_rresp = v.rresp; s_rdata = v.rdat;
`ifdef AXI_LITE_MASTER_WSTRB_EN
        wstrb_in = v.ws;
`endif
        aw0 = aw_total; ar0 = ar_total;
        issue(v.dw, v.dr, v.wa, v.wd, v.ra);
        if (v.dw) begin
            check("w_busy_start", {63'd0, w_busy}, 64'd1);
            check("awvalid_start", {63'd0, axi_awvalid}, 64'd1);
            check("wvalid_start", {63'd0, axi_wvalid}, 64'd1);
            check("w_error_clear", {63'd0, w_error}, 64'd0);
        end
        if (v.dr) begin
            check("r_busy_start", {63'd0, r_busy}, 64'd1);
            check("arvalid_start", {63'd0, axi_arvalid}, 64'd1);
            check("r_error_clear", {63'd0, r_error}, 64'd0);
        end
        fork
            begin if (v.dw) wait_w(wc, awc, wvc); end
            begin if (v.dr) wait_r(rc); end
        join
        if (v.dw) begin
            check("w_done_cycle", wc, v.exp_wcyc);
            check("w_error", {63'd0, w_error}, {63'd0, v.exp_werr});
            check("awvalid_cycles", awc, v.exp_awc);
            check("wvalid_cycles", wvc, v.exp_wc);
            check("aw_addr", mon_awaddr, v.wa);
            check("w_data", mon_wdata, v.wd);
            check("w_strb", mon_wstrb, exp_strb(v.ws));
            check("aw_count", aw_total - aw0, 1);
            check("w_busy_end", {63'd0, w_busy}, 64'd0);
        end
        if (v.dr) begin
            check("r_done_cycle", rc, v.exp_rcyc);
            check("r_error", {63'd0, r_error}, {63'd0, v.exp_rerr});
            check("rdata", rdata, v.rdat);
            check("ar_addr", mon_araddr, v.ra);
            check("ar_count", ar_total - ar0, 1);
            check("r_busy_end", {63'd0, r_busy}, 64'd0);
        end
    endtask

    vec_t tbl[6];

    initial begin
        int  wc, awc, wvc, rc, aw0;
        bit  got, saw;
        vec_t v;

        tbl[0] = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 2'b00,
                   32'h0, 0, 0, 2'b00, 32'h0, 3, 1'b0, 1, 1, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 4'b1100, 3, 0, 0, 2'b00,
                   32'h0, 0, 0, 2'b00, 32'h0, 6, 1'b0, 4, 1, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0, 0, 2'b00,
                   32'h20, 0, 0, 2'b10, 32'h12345678, 0, 1'b0, 0, 0, 3, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h40, 32'h0F0F0F0F, 4'b0001, 0, 2, 1, 2'b11,
                   32'h0, 0, 0, 2'b00, 32'h0, 6, 1'b1, 1, 3, 0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h80, 32'h13579BDF, 4'b1111, 1, 1, 0, 2'b01,
                   32'h84, 2, 1, 2'b00, 32'hA5A55A5A, 4, 1'b0, 2, 2, 6, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 0, 0, 0, 2'b00,
                   32'h88, 0, 3, 2'b10, 32'h0BADF00D, 0, 1'b0, 0, 0, 6, 1'b1};

        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awvalid", {63'd0, axi_awvalid}, 64'd0);
        check("rst_wvalid", {63'd0, axi_wvalid}, 64'd0);
        check("rst_bready", {63'd0, axi_bready}, 64'd0);
        check("rst_arvalid", {63'd0, axi_arvalid}, 64'd0);
        check("rst_rready", {63'd0, axi_rready}, 64'd0);
        check("rst_awaddr", axi_awaddr, 64'd0);
        check("rst_araddr", axi_araddr, 64'd0);
        check("rst_wdata", axi_wdata, 64'd0);
        check("rst_wstrb", axi_wstrb, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_busy", {w_busy, r_busy}, 64'd0);
        check("rst_done", {w_done, r_done}, 64'd0);
        check("rst_error", {w_error, r_error}, 64'd0);
        check("rst_prot", {axi_awprot, axi_arprot}, 64'd0);
        @(negedge aclk) aresetn = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // r_error and rdata from the SLVERR read stay until the next accepted read.
        repeat (4) @(posedge aclk);
        #1;
        check("r_error_hold", {63'd0, r_error}, 64'd1);
        check("rdata_hold", rdata, 32'h0BADF00D);
        v = '{1'b1, 1'b0, 32'h90, 32'h11110000, 4'b1111, 0, 0, 0, 2'b00,
              32'h0, 0, 0, 2'b00, 32'h0, 0, 1'b0, 0, 0, 0, 1'b0};
        run_txn(model(v));
        check("r_error_hold_w", {63'd0, r_error}, 64'd1);
        ar_delay = 0; r_delay = 2; s_rresp = 2'b00; s_rdata = 32'h11223344;
        issue(1'b0, 1'b1, '0, '0, 32'h94);
        check("r_error_cleared", {63'd0, r_error}, 64'd0);
        check("rdata_held_busy", rdata, 32'h0BADF00D);
        wait_r(rc);
        check("rdata_new", rdata, 32'h11223344);
        check("r_cycle_new", rc, 5);

        // Simultaneous start plus extra start_write pulses while busy.
        aw_delay = 2; w_delay = 0; b_delay = 2; s_bresp = 2'b00;
        ar_delay = 3; r_delay = 2; s_rresp = 2'b01; s_rdata = 32'h5EED5EED;
        aw0 = aw_total;
        issue(1'b1, 1'b1, 32'h100, 32'hAAAA0001, 32'h104);
        for (int j = 0; j < 3; j++) begin
            @(negedge aclk);
            start_write = 1'b1; waddr = 32'h200; wdata = 32'hBBBB0002;
            @(posedge aclk); #1;
            start_write = 1'b0;
        end
        fork
            wait_w(wc, awc, wvc);
            wait_r(rc);
        join
        repeat (3) @(posedge aclk);
        #1;
        check("ignore_aw_count", aw_total - aw0, 1);
        check("ignore_awaddr", mon_awaddr, 32'h100);
        check("ignore_wdata", mon_wdata, 32'hAAAA0001);
        check("ignore_w_busy", {63'd0, w_busy}, 64'd0);
        check("both_rdata", rdata, 32'h5EED5EED);
        check("both_r_error", {63'd0, r_error}, 64'd0);

        // Reset while waiting for the write response.
        aw_delay = 0; w_delay = 0; b_delay = 6;
        issue(1'b1, 1'b0, 32'h300, 32'hC0DEC0DE, '0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (axi_bready) got = 1'b1;
            else begin @(posedge aclk); #1; end
        end
        check("bready_before_rst", {63'd0, got}, 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_bready", {63'd0, axi_bready}, 64'd0);
        check("mid_rst_w_busy", {63'd0, w_busy}, 64'd0);
        check("mid_rst_awaddr", axi_awaddr, 64'd0);
        check("mid_rst_wdata", axi_wdata, 64'd0);
        check("mid_rst_wstrb", axi_wstrb, 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            saw |= w_done;
        end
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        saw |= w_done;
        check("rst_no_w_done", {63'd0, saw}, 64'd0);
        v = '{1'b1, 1'b0, 32'h304, 32'h600DF00D, 4'b0110, 0, 0, 0, 2'b00,
              32'h0, 0, 0, 2'b00, 32'h0, 0, 1'b0, 0, 0, 0, 1'b0};
        run_txn(model(v));

        // Re-issue in the same cycle w_done is high.
        aw_delay = 0; w_delay = 0; b_delay = 0; s_bresp = 2'b00;
        aw0 = aw_total;
        issue(1'b1, 1'b0, 32'h400, 32'h55AA55AA, '0);
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge aclk); #1;
            if (w_done) got = 1'b1;
        end
        check("reissue_first_done", {63'd0, got}, 64'd1);
        start_write = 1'b1; waddr = 32'h404; wdata = 32'h66778899;
        @(posedge aclk); #1;
        start_write = 1'b0;
        check("reissue_awvalid", {63'd0, axi_awvalid}, 64'd1);
        check("reissue_w_busy", {63'd0, w_busy}, 64'd1);
        check("reissue_pulse_end", {63'd0, w_done}, 64'd0);
        wait_w(wc, awc, wvc);
        check("reissue_cycle", wc, 3);
        check("reissue_awaddr", mon_awaddr, 32'h404);
        check("reissue_aw_count", aw_total - aw0, 2);

        for (int i = 0; i < 40; i++) begin
            vec_t rv;
            rv.dw    = 1'($urandom_range(0, 1));
            rv.dr    = rv.dw ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.wa    = $urandom() & 32'hFFFF_FFFC;
            rv.wd    = $urandom();
            rv.ws    = 4'($urandom_range(0, 15));
            rv.awd   = $urandom_range(0, 4);
            rv.wdd   = $urandom_range(0, 4);
            rv.bd    = $urandom_range(0, 4);
            rv.bresp = 2'($urandom_range(0, 3));
            rv.ra    = $urandom() & 32'hFFFF_FFFC;
            rv.ard   = $urandom_range(0, 4);
            rv.rd    = $urandom_range(0, 4);
            rv.rresp = 2'($urandom_range(0, 3));
            rv.rdat  = $urandom();
            run_txn(model(rv));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite master engine that turns single-word write and read commands into AXI4-Lite channel transactions. It sits between the command-level bench/user logic (`start_write`/`waddr`/`wdata`, `start_read`/`raddr`) and the AXI4-Lite slave on `axi_lite_if`. It reports completion with `w_done`/`r_done` and protocol errors with `w_error`/`r_error`. Write and read paths are independent and may be in flight simultaneously.

## Interface
- `ADDR_WIDTH`, 32, address width (matches `addr_t`)
- `DATA_WIDTH`, 32, data width (matches `data_t`); must be 32 or 64
- `aclk`  in  1  clock; all logic on rising edge
- `aresetn`  in  1  **one clock; reset is asynchronous and active-low**
- `start_write`  in  1  write command strobe, sampled only when write path idle
- `waddr`  in  ADDR_WIDTH  write address, captured with `start_write`
- `wdata`  in  DATA_WIDTH  write data, captured with `start_write`
- `w_busy`  out  1  write transaction in flight
- `w_done`  out  1  one-cycle pulse: write response received
- `w_error`  out  1  BRESP[1] of last write; held until next accepted write
- `start_read`  in  1  read command strobe, sampled only when read path idle
- `raddr`  in  ADDR_WIDTH  read address, captured with `start_read`
- `r_busy`  out  1  read transaction in flight
- `r_done`  out  1  one-cycle pulse: read data received
- `r_error`  out  1  RRESP[1] of last read; held until next accepted read
- `rdata`  out  DATA_WIDTH  last read data; held until next `r_done`
- `awaddr/awprot/awvalid/awready`, `wdata/wstrb/wvalid/wready`, `bresp/bvalid/bready`, `araddr/arprot/arvalid/arready`, `rdata/rresp/rvalid/rready`  AXI4-Lite master-side channels, standard widths (prot 3, resp 2, strb DATA_WIDTH/8)

## Operation
- Write FSM: `W_IDLE` → `W_ADDR_DATA` → `W_RESP` → `W_IDLE`.
  - `W_IDLE`: on `start_write`, latch `waddr`/`wdata`, set `awvalid`=`wvalid`=1, `w_busy`=1, clear `w_error`.
  - `W_ADDR_DATA`: `awvalid` drops the cycle after `awvalid&awready`; `wvalid` likewise on `wvalid&wready`; handshakes may occur in either order or the same cycle. When both done → `W_RESP`, `bready`=1.
  - `W_RESP`: on `bvalid&bready`: `bready`=0, `w_error`=`bresp[1]`, `w_done` pulse, `w_busy`=0 → `W_IDLE`.
- Read FSM: `R_IDLE` → `R_ADDR` → `R_DATA` → `R_IDLE`, same pattern with `arvalid`, then `rready`=1; on `rvalid&rready` capture `rdata`, `r_error`=`rresp[1]`, pulse `r_done`.
- `awprot`/`arprot` constant 3'b000. OKAY/EXOKAY → error 0; SLVERR/DECERR → error 1.
- `start_*` while corresponding busy: ignored, no queueing.
- Simultaneous `start_write` and `start_read`: both accepted same cycle.
- VALID never deasserted before its READY; address/data stable while VALID high.

## Timing
- All outputs registered. Reset values: all VALID/READY outputs 0, `awaddr`/`araddr`/`wdata`/`rdata` 0, `wstrb` 0, `w_busy`/`r_busy`/`w_done`/`r_done`/`w_error`/`r_error` 0, FSMs in IDLE.
- `start_write` sampled edge N → `awvalid`/`wvalid` high cycle N+1.
- Best case (READY tied 1, response next cycle): `bready` high N+2, `bvalid` at N+2 → `w_done` high cycle N+3. Read identical: `r_done` at N+3.
- Command may be re-issued in the cycle `w_done`/`r_done` is high; accepted (FSM already IDLE).
- `aresetn` low mid-transaction: all outputs to reset values immediately (asynchronous), FSMs to IDLE; no completion pulse issued. Deassertion is synchronised externally.

## Configuration
- `AXI_LITE_MASTER_WSTRB_EN` defined: extra input `wstrb_in` (DATA_WIDTH/8), captured with `start_write` and driven on `wstrb`.
- Not defined: no `wstrb_in` port; `wstrb` driven all-ones during every write (reset value still 0).

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, slave READY always high, BRESP=OKAY → AW/W same beat, `w_done` at N+3, `w_error`=0.
- Write with `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 beat, `awvalid` held 4 cycles with stable address; `w_done` one cycle after B handshake.
- Read 0x0000_0020, slave returns 0x1234_5678 RRESP=SLVERR → `r_done` pulse, `rdata`=0x1234_5678, `r_error`=1 held until next `start_read`.
- `start_write` and `start_read` same cycle, plus second `start_write` while `w_busy` → both first commands complete, second write ignored (exactly one AW handshake).
- `aresetn` low while in `W_RESP` → `bready`, `w_busy` 0 immediately, no `w_done`; new write after release completes normally.
- With `AXI_LITE_MASTER_WSTRB_EN`, `wstrb_in`=4'b0011 → `wstrb`=4'b0011 on W beat; without → 4'b1111.
